// File: rtl/accel_pkg.sv
// Shared definitions for the accelerator datapath: default widths,
// the write-back FSM state type and the signed 8-bit saturation bounds.
package accel_pkg;

    localparam int COLS_DEF   = 8;
    localparam int ACC_W_DEF  = 32;
    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 13;
    localparam int CNT_W_DEF  = 16;
    localparam int SHIFT_W    = 6;

    // Requantized lanes are clamped into the signed 8-bit range.
    localparam int SAT_MAX = 127;
    localparam int SAT_MIN = -128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/requant_lane.sv
// One lane of requantization: round-half-up, arithmetic shift right,
// saturate to a signed DATA_W value. Purely combinational.
module requant_lane
    import accel_pkg::*;
#(
    parameter int ACC_W  = ACC_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [ACC_W-1:0]   acc,
    input  logic [SHIFT_W-1:0] shift,
    output logic [DATA_W-1:0]  q
);

    localparam int SW = $clog2(ACC_W);

    // Bounds carried at the internal ACC_W+1 width so compares stay signed.
    localparam logic signed [ACC_W:0] MAX_V = (ACC_W + 1)'(SAT_MAX);
    localparam logic signed [ACC_W:0] MIN_V = (ACC_W + 1)'(SAT_MIN);

    logic [SW-1:0]          s;
    logic [ACC_W:0]         ext;
    logic [ACC_W:0]         half;
    logic [ACC_W:0]         sum;
    logic signed [ACC_W:0]  shr;

    // Clamp the shift, add the rounding half-LSB one bit wider than the
    // accumulator so it cannot overflow, then shift and saturate.
    always_comb begin
        s    = (shift > SHIFT_W'(ACC_W - 1)) ? SW'(ACC_W - 1) : shift[SW-1:0];
        ext  = {acc[ACC_W-1], acc};
        half = ((ACC_W + 1)'(1) << s) >> 1;
        sum  = ext + half;
        shr  = $signed(sum) >>> s;
        if (shr > MAX_V) begin
            q = MAX_V[DATA_W-1:0];
        end else if (shr < MIN_V) begin
            q = MIN_V[DATA_W-1:0];
        end else begin
            q = shr[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/output_writeback.sv
// Write-back stage behind the systolic array: accepts one row of
// accumulators per handshake, requantizes every lane, and writes the
// packed row to consecutive SRAM words through a single output register.
module output_writeback
    import accel_pkg::*;
#(
    parameter int COLS   = COLS_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     EN,
    input  logic                     START,
    input  logic [ADDR_W-1:0]        OADDR,
    input  logic [SHIFT_W-1:0]       OSHIFT,
    input  logic [CNT_W-1:0]         NROWS,
    input  logic                     ROW_VALID,
    input  logic [COLS*ACC_W-1:0]    ROW_DATA,
    output logic                     ROW_READY,
    output logic                     MEM_WE,
    output logic [ADDR_W-1:0]        MEM_ADDR,
    output logic [COLS*DATA_W-1:0]   MEM_WDATA,
    input  logic                     MEM_READY,
    output logic                     BUSY,
    output logic                     DONE
);

    state_t                   state_reg;
    state_t                   state_next;

    logic [ADDR_W-1:0]        oaddr_reg;
    logic [SHIFT_W-1:0]       oshift_reg;
    logic [CNT_W-1:0]         nrows_reg;
    logic [CNT_W-1:0]         accepted_reg;
    logic [CNT_W-1:0]         written_reg;

    logic                     mem_we_reg;
    logic [ADDR_W-1:0]        mem_addr_reg;
    logic [COLS*DATA_W-1:0]   mem_wdata_reg;

    logic [COLS*DATA_W-1:0]   lane_q;
    logic                     start_fire;
    logic                     accept;
    logic                     complete;
    logic                     last_accept;
    logic                     last_write;

    // One requantizer per column, all sharing the latched shift amount.
    generate
        for (genvar gi = 0; gi < COLS; gi++) begin : g_lane
            requant_lane #(
                .ACC_W  (ACC_W),
                .DATA_W (DATA_W)
            ) u_lane (
                .acc   (ROW_DATA[gi*ACC_W +: ACC_W]),
                .shift (oshift_reg),
                .q     (lane_q[gi*DATA_W +: DATA_W])
            );
        end
    endgenerate

    // Handshake qualifiers; the output register may refill in the same
    // cycle it drains, which sustains one row per cycle.
    always_comb begin
        ROW_READY   = EN && (state_reg == ST_RUN) && (!mem_we_reg || MEM_READY);
        accept      = ROW_VALID && ROW_READY;
        complete    = EN && mem_we_reg && MEM_READY;
        start_fire  = EN && START && (state_reg == ST_IDLE);
        last_accept = (accepted_reg == nrows_reg - CNT_W'(1));
        last_write  = (written_reg == nrows_reg - CNT_W'(1));
    end

    // State register.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; nothing advances while EN is low.
    always_comb begin
        state_next = state_reg;
        if (EN) begin
            case (state_reg)
                ST_IDLE:  if (START) state_next = (NROWS == '0) ? ST_DONE : ST_RUN;
                ST_RUN:   if (accept && last_accept) state_next = ST_DRAIN;
                ST_DRAIN: if (complete && last_write) state_next = ST_DONE;
                ST_DONE:  state_next = ST_IDLE;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    // Layer parameters are captured at START; row counters track accepts and completed writes.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            oaddr_reg    <= '0;
            oshift_reg   <= '0;
            nrows_reg    <= '0;
            accepted_reg <= '0;
            written_reg  <= '0;
        end else if (start_fire) begin
            oaddr_reg    <= OADDR;
            oshift_reg   <= OSHIFT;
            nrows_reg    <= NROWS;
            accepted_reg <= '0;
            written_reg  <= '0;
        end else begin
            if (accept) begin
                accepted_reg <= accepted_reg + CNT_W'(1);
            end
            if (complete) begin
                written_reg <= written_reg + CNT_W'(1);
            end
        end
    end

    // Output register: loads on accept, otherwise clears its request once the write completes.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
        end else if (accept) begin
            mem_we_reg    <= 1'b1;
            mem_addr_reg  <= oaddr_reg + accepted_reg[ADDR_W-1:0];
            mem_wdata_reg <= lane_q;
        end else if (complete) begin
            mem_we_reg    <= 1'b0;
        end
    end

    assign MEM_WE    = mem_we_reg;
    assign MEM_ADDR  = mem_addr_reg;
    assign MEM_WDATA = mem_wdata_reg;
    assign BUSY      = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
    assign DONE      = (state_reg == ST_DONE);

endmodule

// File: tb/tb_output_writeback.sv
// Bench for output_writeback: directed layers checked cycle-by-cycle
// against a transaction-level model, plus literal spot checks.
module tb_output_writeback;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          EN;
    logic          START;
    logic [12:0]   OADDR;
    logic [5:0]    OSHIFT;
    logic [15:0]   NROWS;
    logic          ROW_VALID;
    logic [255:0]  ROW_DATA;
    logic          ROW_READY;
    logic          MEM_WE;
    logic [12:0]   MEM_ADDR;
    logic [63:0]   MEM_WDATA;
    logic          MEM_READY;
    logic          BUSY;
    logic          DONE;

    int errors = 0;
    int checks = 0;

    output_writeback dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .EN        (EN),
        .START     (START),
        .OADDR     (OADDR),
        .OSHIFT    (OSHIFT),
        .NROWS     (NROWS),
        .ROW_VALID (ROW_VALID),
        .ROW_DATA  (ROW_DATA),
        .ROW_READY (ROW_READY),
        .MEM_WE    (MEM_WE),
        .MEM_ADDR  (MEM_ADDR),
        .MEM_WDATA (MEM_WDATA),
        .MEM_READY (MEM_READY),
        .BUSY      (BUSY),
        .DONE      (DONE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference requantization: round half up, floor-shift, clamp.
    function automatic logic [7:0] ref_q(input longint a, input int sh);
        int s;
        longint r;
        s = (sh > 31) ? 31 : sh;
        if (s == 0) r = a;
        else        r = (a + (longint'(1) <<< (s - 1))) >>> s;
        if (r > 127)  r = 127;
        if (r < -128) r = -128;
        return r[7:0];
    endfunction

    function automatic logic [63:0] ref_word(input logic [255:0] row, input logic [5:0] sh);
        logic [63:0] w;
        for (int j = 0; j < 8; j++)
            w[j*8 +: 8] = ref_q(longint'($signed(row[j*32 +: 32])), int'(sh));
        return w;
    endfunction

    function automatic logic [255:0] mk(input int base, input int step);
        logic [255:0] r;
        for (int j = 0; j < 8; j++)
            r[j*32 +: 32] = base + ((j % 2 == 1) ? -(j * step) : (j * step));
        return r;
    endfunction

    // ---------------- transaction-level model ----------------
    bit           m_active, m_done, m_pend, acc_now, cmp_now, chk_en;
    int           m_acc, m_wr, m_n;
    logic [12:0]  m_oaddr, m_addr;
    logic [5:0]   m_sh;
    logic [63:0]  m_data;

    function automatic bit m_ready();
        return (EN === 1'b1) && m_active && (m_acc < m_n) && (!m_pend || (MEM_READY === 1'b1));
    endfunction

    always @(posedge CLK or negedge RESET) begin
        if (RESET !== 1'b1) begin
            m_active = 0; m_done = 0; m_pend = 0;
            m_acc = 0; m_wr = 0; m_n = 0;
        end else if (EN === 1'b1) begin
            acc_now = (ROW_VALID === 1'b1) && m_ready();
            cmp_now = m_pend && (MEM_READY === 1'b1);
            if (m_done) begin
                m_done = 0;
            end else if (START && !m_active) begin
                m_oaddr = OADDR; m_sh = OSHIFT; m_n = int'(NROWS);
                m_acc = 0; m_wr = 0;
                if (NROWS == 0) m_done = 1;
                else            m_active = 1;
            end
            if (cmp_now) begin
                m_pend = 0;
                m_wr++;
                if (m_wr == m_n) begin
                    m_active = 0;
                    m_done = 1;
                end
            end
            if (acc_now) begin
                m_addr = m_oaddr + 13'(m_acc);
                m_data = ref_word(ROW_DATA, m_sh);
                m_pend = 1;
                m_acc++;
            end
        end
    end

    // Compare DUT against the model every cycle, away from the active edge.
    always @(negedge CLK) begin
        if (chk_en && RESET === 1'b1) begin
            check("row_ready", 64'(ROW_READY), 64'(m_ready()));
            check("mem_we", 64'(MEM_WE), 64'(m_pend));
            check("busy", 64'(BUSY), 64'(m_active));
            check("done", 64'(DONE), 64'(m_done));
            if (m_pend) begin
                check("mem_addr", 64'(MEM_ADDR), 64'(m_addr));
                check("mem_wdata", MEM_WDATA, m_data);
            end
        end
    end

    // Log of completed writes as seen on the memory port.
    logic [12:0] log_addr[$];
    logic [63:0] log_data[$];
    always @(negedge CLK) begin
        if (RESET === 1'b1 && EN === 1'b1 && MEM_WE === 1'b1 && MEM_READY === 1'b1) begin
            log_addr.push_back(MEM_ADDR);
            log_data.push_back(MEM_WDATA);
        end
    end

    // Windowed control of MEM_READY and EN, counted in cycles.
    int cyc = 0;
    int stall_lo = -1, stall_hi = -1, en_lo = -1, en_hi = -1;
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            cyc++;
            MEM_READY = !(cyc >= stall_lo && cyc < stall_hi);
            EN        = !(cyc >= en_lo && cyc < en_hi);
        end
    end

    logic [255:0] rows[8];

    task automatic start_layer(input logic [12:0] a, input logic [5:0] sh, input logic [15:0] n);
        log_addr.delete();
        log_data.delete();
        START = 1'b1; OADDR = a; OSHIFT = sh; NROWS = n;
        @(posedge CLK); #1;
        START = 1'b0;
    endtask

    task automatic send_rows(input int n);
        bit got;
        int t;
        for (int i = 0; i < n; i++) begin
            ROW_VALID = 1'b1;
            ROW_DATA  = rows[i];
            t = 0;
            got = 0;
            while (!got && t < 200) begin
                @(negedge CLK);
                got = (ROW_READY === 1'b1) && (EN === 1'b1);
                @(posedge CLK); #1;
                t++;
            end
            check("row_accept", 64'(got), 64'd1);
        end
        ROW_VALID = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 0;
        for (int t = 0; t < 300 && !seen; t++) begin
            @(negedge CLK);
            if (DONE === 1'b1) seen = 1;
        end
        check("done_seen", 64'(seen), 64'd1);
        check("busy_at_done", 64'(BUSY), 64'd0);
        @(posedge CLK); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_row_ready"}, 64'(ROW_READY), 64'd0);
        check({tag, "_mem_we"}, 64'(MEM_WE), 64'd0);
        check({tag, "_mem_addr"}, 64'(MEM_ADDR), 64'd0);
        check({tag, "_mem_wdata"}, MEM_WDATA, 64'd0);
        check({tag, "_busy"}, 64'(BUSY), 64'd0);
        check({tag, "_done"}, 64'(DONE), 64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b0; EN = 1'b1; START = 1'b0; OADDR = '0; OSHIFT = '0; NROWS = '0;
        ROW_VALID = 1'b0; ROW_DATA = '0; MEM_READY = 1'b1; chk_en = 0;
        repeat (2) @(posedge CLK);
        #1;
        check_reset_outputs("reset");
        RESET = 1'b1;
        @(posedge CLK); #1;
        chk_en = 1;

        // Basic layer: rounding down, rounding up, negative rounding.
        rows[0] = '0;
        rows[0][31:0] = 32'h0000_0123;
        rows[0][63:32] = 32'h0000_0128;
        rows[0][95:64] = -32'sd296;
        rows[1] = mk(1000, 77);
        rows[2] = mk(-5000, 333);
        start_layer(13'h100, 6'd4, 16'd3);
        send_rows(3);
        wait_done();
        check("basic_count", 64'(log_addr.size()), 64'd3);
        if (log_addr.size() == 3) begin
            check("basic_addr0", 64'(log_addr[0]), 64'h100);
            check("basic_addr2", 64'(log_addr[2]), 64'h102);
            check("basic_word0", log_data[0], 64'h0000_0000_00EE_1312);
        end

        // Saturation with no shift, then a shift clamped to 31.
        rows[0] = '0;
        rows[0][31:0] = 32'd200;
        rows[0][63:32] = -32'sd300;
        start_layer(13'h010, 6'd0, 16'd1);
        send_rows(1);
        wait_done();
        check("sat_count", 64'(log_data.size()), 64'd1);
        if (log_data.size() == 1) check("sat_word", log_data[0], 64'h807F);
        rows[0] = '0;
        rows[0][31:0] = 32'h7FFF_FFFF;
        rows[0][63:32] = 32'h8000_0000;
        start_layer(13'h020, 6'd40, 16'd1);
        send_rows(1);
        wait_done();
        if (log_data.size() == 1) check("clamp_word", log_data[0], 64'hFF01);
        else check("clamp_count", 64'(log_data.size()), 64'd1);

        // Backpressure: MEM_READY low for three cycles mid-stream.
        for (int i = 0; i < 6; i++) rows[i] = mk(i * 1234 - 3000, 100 + i);
        stall_lo = cyc + 4; stall_hi = cyc + 7;
        start_layer(13'h200, 6'd3, 16'd6);
        send_rows(6);
        wait_done();
        stall_lo = -1; stall_hi = -1;
        check("bp_count", 64'(log_addr.size()), 64'd6);
        for (int i = 0; i < 6 && i < log_addr.size(); i++)
            check("bp_addr", 64'(log_addr[i]), 64'(13'h200 + 13'(i)));

        // NROWS = 0: DONE pulse straight away, no writes.
        start_layer(13'h300, 6'd0, 16'd0);
        check("zero_done", 64'(DONE), 64'd1);
        check("zero_busy", 64'(BUSY), 64'd0);
        @(posedge CLK); #1;
        check("zero_done_clear", 64'(DONE), 64'd0);
        repeat (3) @(posedge CLK);
        #1;
        check("zero_count", 64'(log_addr.size()), 64'd0);

        // Address wrap at the top of the word-address space.
        rows[0] = mk(40, 9);
        rows[1] = mk(-40, 11);
        start_layer(13'h1FFF, 6'd1, 16'd2);
        send_rows(2);
        wait_done();
        check("wrap_count", 64'(log_addr.size()), 64'd2);
        if (log_addr.size() == 2) begin
            check("wrap_addr0", 64'(log_addr[0]), 64'h1FFF);
            check("wrap_addr1", 64'(log_addr[1]), 64'h0000);
        end

        // START while busy must not disturb the running layer.
        for (int i = 0; i < 4; i++) rows[i] = mk(i * 500 + 7, 60);
        start_layer(13'h040, 6'd2, 16'd4);
        START = 1'b1; OADDR = 13'h900; OSHIFT = 6'd0; NROWS = 16'd1;
        fork
            begin @(posedge CLK); #1; START = 1'b0; end
            send_rows(4);
        join
        wait_done();
        check("rs_count", 64'(log_addr.size()), 64'd4);
        if (log_addr.size() == 4) check("rs_addr3", 64'(log_addr[3]), 64'h043);

        // EN low for two cycles while rows and MEM_READY are offered.
        for (int i = 0; i < 4; i++) rows[i] = mk(-i * 900, 45);
        en_lo = cyc + 2; en_hi = cyc + 4;
        start_layer(13'h0A0, 6'd5, 16'd4);
        send_rows(4);
        wait_done();
        en_lo = -1; en_hi = -1;
        check("en_count", 64'(log_addr.size()), 64'd4);
        if (log_addr.size() == 4) check("en_addr3", 64'(log_addr[3]), 64'h0A3);

        // Reset during DRAIN with a write stuck pending.
        rows[0] = mk(123, 4);
        stall_lo = cyc; stall_hi = cyc + 1000;
        start_layer(13'h500, 6'd0, 16'd1);
        send_rows(1);
        repeat (2) @(posedge CLK);
        #1;
        check("drain_we", 64'(MEM_WE), 64'd1);
        #2;
        RESET = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        stall_lo = -1; stall_hi = -1;
        @(posedge CLK); #1;
        RESET = 1'b1;
        @(posedge CLK); #1;

        // Fresh layer after reset.
        rows[0] = '0;
        rows[0][31:0] = 32'h0000_0123;
        rows[0][63:32] = 32'h0000_0128;
        rows[0][95:64] = -32'sd296;
        rows[1] = mk(2222, 31);
        start_layer(13'h600, 6'd4, 16'd2);
        send_rows(2);
        wait_done();
        check("fresh_count", 64'(log_addr.size()), 64'd2);
        if (log_addr.size() == 2) begin
            check("fresh_addr0", 64'(log_addr[0]), 64'h600);
            check("fresh_word0", log_data[0], 64'h0000_0000_00EE_1312);
        end

        repeat (2) @(posedge CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
